writeback_unit: RTL
===================

# writeback_unit

Write-side owner of the general-purpose register file. Arbitrates ALU and load/store-unit results onto the file's single write port through a registered write stage. Tracks outstanding load destinations in a scoreboard and produces the decode-stage read-after-write stall. Optionally bypasses the in-flight write to the read operands.

## Interface
- `RISCV_WORD_WIDTH`, default 32 (shared define): data width.
- `GP_REG_COUNT`, default 32 (shared define): register count. `AW = $clog2(GP_REG_COUNT)`.
- `FORCE_AFTER`, default 2: consecutive LSU losses before the LSU is forced to win.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  **reset; synchronous, active-low.**
- alu_valid_i  in  1  ALU result present.
- alu_ready_o  out  1  ALU result accepted this cycle.
- alu_rd_i  in  AW  ALU destination.
- alu_data_i  in  WORD  ALU result.
- lsu_valid_i  in  1  load result present; held with its payload until accepted.
- lsu_ready_o  out  1  load result accepted this cycle.
- lsu_rd_i  in  AW  load destination.
- lsu_data_i  in  WORD  load data.
- issue_load_i  in  1  decode issues a load this cycle.
- issue_rd_i  in  AW  destination of the issued load.
- issue_ready_o  out  1  load issue accepted.
- rs1_i, rs2_i  in  AW  decode source addresses; these also drive the register file read addresses.
- rf_rdata_1_i, rf_rdata_2_i  in  WORD  register file read data.
- rs1_data_o, rs2_data_o  out  WORD  operand data after bypass.
- stall_o  out  1  decode must hold.
- rf_we_o  out  1  register file write enable; registered.
- rf_waddr_o  out  AW  register file write address; registered.
- rf_wdata_o  out  WORD  register file write data; registered.

## Operation
**Write port**
- The arbitration winner is registered into `rf_we_o`/`rf_waddr_o`/`rf_wdata_o`.
- The file commits the write on the following edge.
- A winner with rd == 0 is consumed, but `rf_we_o` stays 0.

**Arbitration FSM**
- `ALU_PRI` (reset state): ALU wins whenever `alu_valid_i` is high.
  - If the LSU is valid and loses, the loss counter increments.
  - When the counter reaches `FORCE_AFTER`, go to `LSU_FORCE`.
- `LSU_FORCE`: `alu_ready_o`=0 and the LSU wins.
  - After the LSU handshake, the counter clears and the FSM returns to `ALU_PRI`.
- The counter clears on any LSU acceptance.
- `alu_ready_o = ~(state == LSU_FORCE)`.
- `lsu_ready_o = lsu_valid_i & (state == LSU_FORCE | ~alu_valid_i)`.

**Scoreboard** (one pending bit per register)
- Set: on `issue_load_i & issue_ready_o` with rd ≠ 0.
- Clear: on the LSU handshake for `lsu_rd_i`. If a set and a clear hit the same register in the same cycle, the set wins.
- `issue_ready_o = ~pending[issue_rd_i]`, which holds off WAW. x0 is never pending.

**Stall**
- `stall_o` = `(pending[rs1_i] | pending[rs2_i]) | ~issue_ready_o&issue_load_i`, plus the bypass hazard term described below.
- Source x0 never stalls.

**Reset**
- Synchronous reset clears the scoreboard, the FSM and the write stage.
- Any in-flight write is dropped; the sources re-present.

## Timing
- Reset values: `rf_we_o`=0, `rf_waddr_o`=0, `rf_wdata_o`=0, FSM=`ALU_PRI`, scoreboard all clear.
- `stall_o`, the ready outputs and the `rs*_data_o` outputs are combinational from state and inputs.
- Latency: handshake at edge N → `rf_we_o` high during cycle N+1 → value readable from the file from cycle N+2.
- The scoreboard bit clears at the handshake edge. The dependent read in cycle N+1 therefore needs either the bypass or a stall.

## Configuration
- `WB_FORWARDING_EN` defined:
  - `rsX_data_o = rf_wdata_o` when `rf_we_o` is high and `rf_waddr_o == rsX_i` ≠ 0.
  - Otherwise `rsX_data_o = rf_rdata_X_i`.
  - No extra stall term.
- `WB_FORWARDING_EN` undefined:
  - `rsX_data_o = rf_rdata_X_i`.
  - `stall_o` is additionally asserted while `rf_we_o` is high and `rf_waddr_o` matches a nonzero `rs1_i`/`rs2_i`.

## Structure
- Shared package:
  - arbitration FSM state enum `wb_arb_state_t {ALU_PRI, LSU_FORCE}`;
  - `FORCE_AFTER` default;
  - `AW`, derived from `GP_REG_COUNT`.
- Sub-module `wb_scoreboard`: pending bit vector, set/clear ports, and two lookup ports plus the issue lookup.

## Test plan
- Reset:
  - Stimulus: hold rst_n=0 two cycles while all valids are high.
  - Required: `rf_we_o`=0, scoreboard clear, `stall_o`=0 for `rs1_i`=5.
- ALU write:
  - Stimulus: ALU valid, rd=3, data 0xDEADBEEF at edge N.
  - Required: `rf_we_o`=1, `rf_waddr_o`=3, `rf_wdata_o`=0xDEADBEEF in cycle N+1.
  - Also: with rd=0, `rf_we_o` stays 0.
- Load stall:
  - Stimulus: issue load rd=7, then read `rs1_i`=7.
  - Required: `stall_o`=1 until the LSU handshake for rd 7; `issue_ready_o`=0 for a second issue to rd 7.
- Starvation:
  - Stimulus: ALU and LSU both valid continuously.
  - Required: the ALU wins 2 cycles; the 3rd cycle has `alu_ready_o`=0 and `lsu_ready_o`=1.
- Bypass:
  - Stimulus: load result rd=9, data 0x1234 accepted at edge N; `rs2_i`=9 in cycle N+1.
  - Required, EN defined: `rs2_data_o`=0x1234 with `stall_o`=0.
  - Required, EN undefined: `stall_o`=1 in N+1 and the file value 0x1234 in N+2.
- Set/clear collision:
  - Stimulus: LSU handshake for rd 4 in the same cycle as an issue to rd 4 (`issue_ready_o`=0, so this is tested with the issue of a different rd).
  - Required: bit 4 clears and the other bit sets.

Source files
------------

// File: rtl/writeback_unit_pkg.sv
// Shared types and constants for the writeback unit: the arbitration
// state encoding, the default LSU anti-starvation threshold and the
// register-file geometry derived from the shared defines.

`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

`ifndef GP_REG_COUNT
`define GP_REG_COUNT 32
`endif

package writeback_unit_pkg;

   localparam int WORD                = `RISCV_WORD_WIDTH;
   localparam int NREG                = `GP_REG_COUNT;
   localparam int AW                  = $clog2(NREG);
   localparam int FORCE_AFTER_DEFAULT = 2;

   typedef enum logic {
      ALU_PRI   = 1'b0,
      LSU_FORCE = 1'b1
   } wb_arb_state_t;

   // One-hot decode of a register index; x0 never produces a bit because
   // it is hard-wired and must never be tracked.
   function automatic logic [NREG-1:0] reg_onehot(input logic [AW-1:0] idx);
      logic [NREG-1:0] v;
      v = {NREG{1'b0}};
      for (int i = 1; i < NREG; i++) begin
         v[i] = (idx == AW'(i));
      end
      return v;
   endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the writeback unit's pipeline-facing signals: ALU and LSU
// result handshakes, load issue, operand read path and the register-file
// write port. The slave modport is the writeback unit itself.

interface writeback_unit_if;
   import writeback_unit_pkg::*;

   logic            alu_valid_i;
   logic            alu_ready_o;
   logic [AW-1:0]   alu_rd_i;
   logic [WORD-1:0] alu_data_i;

   logic            lsu_valid_i;
   logic            lsu_ready_o;
   logic [AW-1:0]   lsu_rd_i;
   logic [WORD-1:0] lsu_data_i;

   logic            issue_load_i;
   logic [AW-1:0]   issue_rd_i;
   logic            issue_ready_o;

   logic [AW-1:0]   rs1_i;
   logic [AW-1:0]   rs2_i;
   logic [WORD-1:0] rf_rdata_1_i;
   logic [WORD-1:0] rf_rdata_2_i;
   logic [WORD-1:0] rs1_data_o;
   logic [WORD-1:0] rs2_data_o;
   logic            stall_o;

   logic            rf_we_o;
   logic [AW-1:0]   rf_waddr_o;
   logic [WORD-1:0] rf_wdata_o;

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output lsu_valid_i, lsu_rd_i, lsu_data_i,
      output issue_load_i, issue_rd_i,
      output rs1_i, rs2_i, rf_rdata_1_i, rf_rdata_2_i,
      input  alu_ready_o, lsu_ready_o, issue_ready_o,
      input  rs1_data_o, rs2_data_o, stall_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o
   );

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i,
      input  issue_load_i, issue_rd_i,
      input  rs1_i, rs2_i, rf_rdata_1_i, rf_rdata_2_i,
      output alu_ready_o, lsu_ready_o, issue_ready_o,
      output rs1_data_o, rs2_data_o, stall_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o
   );

endinterface

// File: rtl/writeback_unit_scoreboard.sv
// Pending-load scoreboard: one bit per register, set when a load is
// issued and cleared when its data is accepted. A set wins over a clear
// to the same register in the same cycle. x0 is never pending.

module wb_scoreboard
   import writeback_unit_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          set_en,
   input  logic [AW-1:0] set_addr,
   input  logic          clr_en,
   input  logic [AW-1:0] clr_addr,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   input  logic [AW-1:0] issue_addr,
   output logic          pend_a,
   output logic          pend_b,
   output logic          pend_issue
);

   logic [NREG-1:0] pending_r;
   logic [NREG-1:0] pending_next_s;
   logic [NREG-1:0] set_mask_s;
   logic [NREG-1:0] clr_mask_s;

   // Next pending vector: clear first, then set, so a same-cycle set wins.
   always_comb begin
      set_mask_s = {NREG{1'b0}};
      clr_mask_s = {NREG{1'b0}};
      if (set_en) begin
         set_mask_s = reg_onehot(set_addr);
      end else begin
         set_mask_s = {NREG{1'b0}};
      end
      if (clr_en) begin
         clr_mask_s = reg_onehot(clr_addr);
      end else begin
         clr_mask_s = {NREG{1'b0}};
      end
      pending_next_s = (pending_r & ~clr_mask_s) | set_mask_s;
   end

   // Pending vector register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pending_r <= {NREG{1'b0}};
      end else begin
         pending_r <= pending_next_s;
      end
   end

   assign pend_a     = pending_r[rd_addr_a];
   assign pend_b     = pending_r[rd_addr_b];
   assign pend_issue = pending_r[issue_addr];

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: arbitrates ALU and LSU results onto the single register
// file write port through a registered write stage, tracks outstanding
// loads and produces the decode read-after-write stall.
// Optional feature macro: WB_FORWARDING_EN -- when defined, the write in
// flight is bypassed to the read operands instead of stalling on it.

module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int FORCE_AFTER = FORCE_AFTER_DEFAULT
)(
   input  logic             clk,
   input  logic             rst_n,
   writeback_unit_if.slave  bus
);

   localparam int             CW          = $clog2(FORCE_AFTER + 1);
   localparam logic [CW-1:0]  FORCE_LIMIT = CW'(FORCE_AFTER);

   wb_arb_state_t   state_r;
   wb_arb_state_t   state_next_s;
   logic [CW-1:0]   cnt_r;
   logic [CW-1:0]   cnt_next_s;
   logic [CW-1:0]   cnt_inc_s;

   logic            alu_ready_s;
   logic            lsu_ready_s;
   logic            alu_hs_s;
   logic            lsu_hs_s;
   logic            win_valid_s;
   logic [AW-1:0]   win_rd_s;
   logic [WORD-1:0] win_data_s;

   logic            we_r;
   logic [AW-1:0]   waddr_r;
   logic [WORD-1:0] wdata_r;

   logic            rs1_pend_s;
   logic            rs2_pend_s;
   logic            issue_pend_s;
   logic            issue_ready_s;
   logic            set_en_s;
   logic            hazard_s;
   logic [WORD-1:0] rs1_data_s;
   logic [WORD-1:0] rs2_data_s;

   // Ready signals and winner selection; the two handshakes are exclusive.
   always_comb begin
      alu_ready_s = (state_r != LSU_FORCE);
      lsu_ready_s = bus.lsu_valid_i & ((state_r == LSU_FORCE) | ~bus.alu_valid_i);
      alu_hs_s    = bus.alu_valid_i & alu_ready_s;
      lsu_hs_s    = bus.lsu_valid_i & lsu_ready_s;
      win_valid_s = alu_hs_s | lsu_hs_s;
      if (alu_hs_s) begin
         win_rd_s   = bus.alu_rd_i;
         win_data_s = bus.alu_data_i;
      end else begin
         win_rd_s   = bus.lsu_rd_i;
         win_data_s = bus.lsu_data_i;
      end
   end

   // Arbitration next state: count LSU losses, force the LSU after enough.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      cnt_inc_s    = cnt_r + CW'(1);
      case (state_r)
         ALU_PRI: begin
            if (lsu_hs_s) begin
               cnt_next_s = {CW{1'b0}};
            end else if (alu_hs_s & bus.lsu_valid_i) begin
               cnt_next_s = cnt_inc_s;
               if (cnt_inc_s >= FORCE_LIMIT) begin
                  state_next_s = LSU_FORCE;
               end else begin
                  state_next_s = ALU_PRI;
               end
            end else begin
               cnt_next_s = cnt_r;
            end
         end
         LSU_FORCE: begin
            if (lsu_hs_s) begin
               state_next_s = ALU_PRI;
               cnt_next_s   = {CW{1'b0}};
            end else begin
               state_next_s = LSU_FORCE;
            end
         end
         default: begin
            state_next_s = ALU_PRI;
            cnt_next_s   = {CW{1'b0}};
         end
      endcase
   end

   // Arbitration state and loss counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ALU_PRI;
         cnt_r   <= {CW{1'b0}};
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Registered write stage; an x0 winner is consumed without a write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         we_r    <= 1'b0;
         waddr_r <= {AW{1'b0}};
         wdata_r <= {WORD{1'b0}};
      end else if (win_valid_s) begin
         we_r    <= (win_rd_s != {AW{1'b0}});
         waddr_r <= win_rd_s;
         wdata_r <= win_data_s;
      end else begin
         we_r    <= 1'b0;
      end
   end

   assign issue_ready_s = ~issue_pend_s;
   assign set_en_s      = bus.issue_load_i & issue_ready_s & (bus.issue_rd_i != {AW{1'b0}});

   wb_scoreboard u_scoreboard (
      .clk        (clk),
      .rst_n      (rst_n),
      .set_en     (set_en_s),
      .set_addr   (bus.issue_rd_i),
      .clr_en     (lsu_hs_s),
      .clr_addr   (bus.lsu_rd_i),
      .rd_addr_a  (bus.rs1_i),
      .rd_addr_b  (bus.rs2_i),
      .issue_addr (bus.issue_rd_i),
      .pend_a     (rs1_pend_s),
      .pend_b     (rs2_pend_s),
      .pend_issue (issue_pend_s)
   );

   // Operand path: bypass the write in flight, or stall decode on it.
   always_comb begin
      hazard_s   = 1'b0;
      rs1_data_s = bus.rf_rdata_1_i;
      rs2_data_s = bus.rf_rdata_2_i;
`ifdef WB_FORWARDING_EN
      if (we_r & (waddr_r == bus.rs1_i) & (bus.rs1_i != {AW{1'b0}})) begin
         rs1_data_s = wdata_r;
      end else begin
         rs1_data_s = bus.rf_rdata_1_i;
      end
      if (we_r & (waddr_r == bus.rs2_i) & (bus.rs2_i != {AW{1'b0}})) begin
         rs2_data_s = wdata_r;
      end else begin
         rs2_data_s = bus.rf_rdata_2_i;
      end
`else
      hazard_s = we_r & (((waddr_r == bus.rs1_i) & (bus.rs1_i != {AW{1'b0}})) |
                         ((waddr_r == bus.rs2_i) & (bus.rs2_i != {AW{1'b0}})));
`endif
   end

   assign bus.alu_ready_o   = alu_ready_s;
   assign bus.lsu_ready_o   = lsu_ready_s;
   assign bus.issue_ready_o = issue_ready_s;
   assign bus.stall_o       = rs1_pend_s | rs2_pend_s |
                              (bus.issue_load_i & ~issue_ready_s) | hazard_s;
   assign bus.rs1_data_o    = rs1_data_s;
   assign bus.rs2_data_o    = rs2_data_s;
   assign bus.rf_we_o       = we_r;
   assign bus.rf_waddr_o    = waddr_r;
   assign bus.rf_wdata_o    = wdata_r;

endmodule
